// File: rtl/regfile_scan.sv
// Parametrised register file with two combinational read ports, optional write bypass
// and a ready/valid scanner that streams every register to a debug consumer.
module regfile_scan #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned AW       = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            dump_start,
   input  logic            dump_ready,
   output logic            dump_valid,
   output logic [AW-1:0]   dump_addr,
   output logic [XLEN-1:0] dump_data,
   output logic            dump_busy,
   output logic            dump_done
);

   localparam int unsigned   DEPTH = 1 << AW;
   localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

   typedef enum logic {IDLE, SCAN} state_e;

   logic [XLEN-1:0] regs_q [DEPTH];
   logic            wr_legal;

   state_e          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            valid_q, valid_d;
   logic            done_q, done_d;

   assign wr_legal = we && (32'(wa) < NREGS) && !(ZERO_REG && (wa == '0));

   // Entries at or above NREGS are never written and stay at their reset value.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_legal) begin
         regs_q[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = regs_q[ra1];
      if ((32'(ra1) >= NREGS) || (ZERO_REG && (ra1 == '0))) begin
         rd1 = '0;
      end else if (BYPASS && wr_legal && (wa == ra1)) begin
         rd1 = wd;
      end
   end

   always_comb begin
      rd2 = regs_q[ra2];
      if ((32'(ra2) >= NREGS) || (ZERO_REG && (ra2 == '0))) begin
         rd2 = '0;
      end else if (BYPASS && wr_legal && (wa == ra2)) begin
         rd2 = wd;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // Snapshots read regs_q directly, so a write on the load edge is never captured.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (dump_start) begin
               state_d = SCAN;
               idx_d   = '0;
               data_d  = regs_q[0];
               valid_d = 1'b1;
            end
         end
         SCAN: begin
            if (valid_q && dump_ready) begin
               if (idx_q == LAST) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_q + AW'(1);
                  data_d = regs_q[idx_q + AW'(1)];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dump_busy  = (state_q == SCAN);
      dump_valid = valid_q;
      dump_addr  = idx_q;
      dump_data  = data_q;
      dump_done  = done_q;
   end

endmodule

// File: tb/tb_regfile_scan.sv
// Bench for regfile_scan: three configurations checked every cycle against a
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_regfile_scan;

   localparam int unsigned NR  [3] = '{32, 16, 12};
   localparam bit          ZR  [3] = '{1'b1, 1'b0, 1'b1};
   localparam bit          BP  [3] = '{1'b1, 1'b0, 1'b1};
   localparam logic [31:0] MSK [3] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_00FF};
   localparam logic [31:0] AM  [3] = '{32'd31, 32'd15, 32'd15};

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic        we_s    [3];
   logic [31:0] wa_s    [3];
   logic [31:0] wd_s    [3];
   logic [31:0] ra1_s   [3];
   logic [31:0] ra2_s   [3];
   logic        start_s [3];
   logic        ready_s [3];

   logic [31:0] rd1_0, rd2_0, dd_0;
   logic [4:0]  da_0;
   logic        dv_0, db_0, dn_0;
   logic [15:0] rd1_1, rd2_1, dd_1;
   logic [3:0]  da_1;
   logic        dv_1, db_1, dn_1;
   logic [7:0]  rd1_2, rd2_2, dd_2;
   logic [3:0]  da_2;
   logic        dv_2, db_2, dn_2;

   logic [31:0] rd1_a [3];
   logic [31:0] rd2_a [3];
   logic [31:0] dd_a  [3];
   logic [31:0] da_a  [3];
   logic        dv_a  [3];
   logic        db_a  [3];
   logic        dn_a  [3];

   assign rd1_a[0] = rd1_0;       assign rd1_a[1] = 32'(rd1_1); assign rd1_a[2] = 32'(rd1_2);
   assign rd2_a[0] = rd2_0;       assign rd2_a[1] = 32'(rd2_1); assign rd2_a[2] = 32'(rd2_2);
   assign dd_a[0]  = dd_0;        assign dd_a[1]  = 32'(dd_1);  assign dd_a[2]  = 32'(dd_2);
   assign da_a[0]  = 32'(da_0);   assign da_a[1]  = 32'(da_1);  assign da_a[2]  = 32'(da_2);
   assign dv_a[0]  = dv_0;        assign dv_a[1]  = dv_1;       assign dv_a[2]  = dv_2;
   assign db_a[0]  = db_0;        assign db_a[1]  = db_1;       assign db_a[2]  = db_2;
   assign dn_a[0]  = dn_0;        assign dn_a[1]  = dn_1;       assign dn_a[2]  = dn_2;

   regfile_scan #(.XLEN(32), .NREGS(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
      .clock(clock), .reset(reset), .we(we_s[0]), .wa(wa_s[0][4:0]), .wd(wd_s[0]),
      .ra1(ra1_s[0][4:0]), .ra2(ra2_s[0][4:0]), .rd1(rd1_0), .rd2(rd2_0),
      .dump_start(start_s[0]), .dump_ready(ready_s[0]), .dump_valid(dv_0),
      .dump_addr(da_0), .dump_data(dd_0), .dump_busy(db_0), .dump_done(dn_0));

   regfile_scan #(.XLEN(16), .NREGS(16), .AW(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
      .clock(clock), .reset(reset), .we(we_s[1]), .wa(wa_s[1][3:0]), .wd(wd_s[1][15:0]),
      .ra1(ra1_s[1][3:0]), .ra2(ra2_s[1][3:0]), .rd1(rd1_1), .rd2(rd2_1),
      .dump_start(start_s[1]), .dump_ready(ready_s[1]), .dump_valid(dv_1),
      .dump_addr(da_1), .dump_data(dd_1), .dump_busy(db_1), .dump_done(dn_1));

   regfile_scan #(.XLEN(8), .NREGS(12), .AW(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut2 (
      .clock(clock), .reset(reset), .we(we_s[2]), .wa(wa_s[2][3:0]), .wd(wd_s[2][7:0]),
      .ra1(ra1_s[2][3:0]), .ra2(ra2_s[2][3:0]), .rd1(rd1_2), .rd2(rd2_2),
      .dump_start(start_s[2]), .dump_ready(ready_s[2]), .dump_valid(dv_2),
      .dump_addr(da_2), .dump_data(dd_2), .dump_busy(db_2), .dump_done(dn_2));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: register contents as a plain array, scan as "busy + current index + snapshot".
   logic [31:0] mreg   [3][32];
   logic        m_busy [3];
   logic        m_done [3];
   logic [31:0] m_addr [3];
   logic [31:0] m_data [3];

   function automatic logic legal(input int k, input logic [31:0] a);
      return (a < NR[k]) && !(ZR[k] && (a == 0));
   endfunction

   function automatic logic [31:0] exp_rd(input int k, input logic [31:0] ra);
      if ((ra >= NR[k]) || (ZR[k] && (ra == 0))) return 32'h0;
      if (BP[k] && we_s[k] && (wa_s[k] == ra) && legal(k, wa_s[k])) return wd_s[k] & MSK[k];
      return mreg[k][ra[4:0]];
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) mreg[k][i] = 32'h0;
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
            m_addr[k] = 32'h0;
            m_data[k] = 32'h0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            m_done[k] = 1'b0;
            if (!m_busy[k]) begin
               if (start_s[k]) begin
                  m_busy[k] = 1'b1;
                  m_addr[k] = 32'h0;
                  m_data[k] = mreg[k][0];
               end
            end else if (ready_s[k]) begin
               if (m_addr[k] == NR[k] - 1) begin
                  m_busy[k] = 1'b0;
                  m_done[k] = 1'b1;
               end else begin
                  m_addr[k] = m_addr[k] + 1;
                  m_data[k] = mreg[k][m_addr[k][4:0]];
               end
            end
            if (we_s[k] && legal(k, wa_s[k])) mreg[k][wa_s[k][4:0]] = wd_s[k] & MSK[k];
         end
      end
   end

   always @(negedge clock) begin
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dut%0d.rd1", k),   rd1_a[k], exp_rd(k, ra1_s[k]));
         chk($sformatf("dut%0d.rd2", k),   rd2_a[k], exp_rd(k, ra2_s[k]));
         chk($sformatf("dut%0d.valid", k), 32'(dv_a[k]), 32'(m_busy[k]));
         chk($sformatf("dut%0d.busy", k),  32'(db_a[k]), 32'(m_busy[k]));
         chk($sformatf("dut%0d.done", k),  32'(dn_a[k]), 32'(m_done[k]));
         chk($sformatf("dut%0d.addr", k),  da_a[k], m_addr[k]);
         chk($sformatf("dut%0d.data", k),  dd_a[k], m_data[k]);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      for (int k = 0; k < 3; k++) begin
         we_s[k] = 1'b0; wa_s[k] = 32'h0; wd_s[k] = 32'h0;
         ra1_s[k] = 32'h0; ra2_s[k] = 32'h0;
         start_s[k] = 1'b0; ready_s[k] = 1'b0;
      end
   endtask

   initial begin
      int          beats;
      logic [31:0] seen3;
      logic        wrote;
      logic        done;
      idle();
      repeat (3) tick();
      chk("rst.valid", 32'(dv_a[0]), 32'h0);
      chk("rst.busy",  32'(db_a[0]), 32'h0);
      chk("rst.addr",  da_a[0], 32'h0);
      chk("rst.data",  dd_a[0], 32'h0);
      chk("rst.done",  32'(dn_a[1]), 32'h0);
      reset = 1'b1;
      tick();

      // basic write/read and reset clearing
      we_s[0] = 1'b1; wa_s[0] = 32'd5; wd_s[0] = 32'hDEAD_BEEF;
      tick();
      we_s[0] = 1'b0; ra1_s[0] = 32'd5; ra2_s[0] = 32'd6;
      #1;
      chk("t1.rd1", rd1_a[0], 32'hDEAD_BEEF);
      chk("t1.rd2", rd2_a[0], 32'h0);
      reset = 1'b0;
      #1;
      chk("t1.rd1_after_reset", rd1_a[0], 32'h0);
      reset = 1'b1;
      tick();

      // zero register vs plain register 0
      for (int k = 0; k < 2; k++) begin
         we_s[k] = 1'b1; wa_s[k] = 32'd0; wd_s[k] = 32'h1234; ra1_s[k] = 32'd0;
      end
      #1;
      chk("t2.zero_reg", rd1_a[0], 32'h0);
      chk("t2.nobypass_pre", rd1_a[1], 32'h0);
      tick();
      we_s[0] = 1'b0; we_s[1] = 1'b0;
      #1;
      chk("t2.zero_reg_after", rd1_a[0], 32'h0);
      chk("t2.reg0_written", rd1_a[1], 32'h1234);

      // bypass vs no bypass
      we_s[0] = 1'b1; wa_s[0] = 32'd7; wd_s[0] = 32'hA5A5_A5A5; ra1_s[0] = 32'd7;
      we_s[1] = 1'b1; wa_s[1] = 32'd7; wd_s[1] = 32'hA5A5;      ra1_s[1] = 32'd7;
      #1;
      chk("t3.bypass", rd1_a[0], 32'hA5A5_A5A5);
      chk("t3.nobypass_old", rd1_a[1], 32'h0);
      tick();
      we_s[0] = 1'b0; we_s[1] = 1'b0;
      #1;
      chk("t3.nobypass_new", rd1_a[1], 32'hA5A5);

      // full back-to-back scan
      for (int i = 1; i < 32; i++) begin
         we_s[0] = 1'b1; wa_s[0] = 32'(i); wd_s[0] = 32'(i) * 32'h11;
         tick();
      end
      we_s[0] = 1'b0; ready_s[0] = 1'b1; start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      for (int i = 0; i < 32; i++) begin
         #1;
         chk($sformatf("t4.valid[%0d]", i), 32'(dv_a[0]), 32'h1);
         chk($sformatf("t4.addr[%0d]", i), da_a[0], 32'(i));
         chk($sformatf("t4.data[%0d]", i), dd_a[0], 32'(i) * 32'h11);
         tick();
      end
      #1;
      chk("t4.done", 32'(dn_a[0]), 32'h1);
      chk("t4.busy_after", 32'(db_a[0]), 32'h0);
      chk("t4.valid_after", 32'(dv_a[0]), 32'h0);
      tick();
      #1;
      chk("t4.done_one_cycle", 32'(dn_a[0]), 32'h0);

      // stalled scan with write to the presented register, and ignored mid-scan start
      start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      beats = 0; seen3 = 32'h0; wrote = 1'b0; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         ready_s[0] = ((c % 4) == 0) || ((c % 4) == 3);
         we_s[0] = 1'b0;
         start_s[0] = (c == 20);
         #1;
         if (dn_a[0]) begin
            done = 1'b1;
         end else begin
            if (dv_a[0] && ready_s[0]) begin
               beats++;
               if (da_a[0] == 32'd3) seen3 = dd_a[0];
            end
            if (dv_a[0] && !ready_s[0] && (da_a[0] == 32'd3) && !wrote) begin
               chk("t5.stall_data", dd_a[0], 32'h33);
               we_s[0] = 1'b1; wa_s[0] = 32'd3; wd_s[0] = 32'hFFFF_FFFF;
               wrote = 1'b1;
            end
            tick();
         end
      end
      chk("t5.done_seen", 32'(done), 32'h1);
      chk("t5.beats", 32'(beats), 32'd32);
      chk("t5.beat3", seen3, 32'h33);
      we_s[0] = 1'b0; ready_s[0] = 1'b1; start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      seen3 = 32'h0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (dn_a[0]) done = 1'b1;
         else begin
            if (dv_a[0] && (da_a[0] == 32'd3)) seen3 = dd_a[0];
            tick();
         end
      end
      chk("t5.rescan_done", 32'(done), 32'h1);
      chk("t5.rescan_beat3", seen3, 32'hFFFF_FFFF);
      ready_s[0] = 1'b0;

      // 16-entry configuration: top index, full scan, reset mid-scan
      we_s[1] = 1'b1; wa_s[1] = 32'd15; wd_s[1] = 32'hBEEF;
      tick();
      we_s[1] = 1'b0; ra1_s[1] = 32'd15;
      #1;
      chk("t6.top_index", rd1_a[1], 32'hBEEF);
      ready_s[1] = 1'b1; start_s[1] = 1'b1;
      tick();
      start_s[1] = 1'b0;
      beats = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (dn_a[1]) done = 1'b1;
         else begin
            if (dv_a[1]) beats++;
            tick();
         end
      end
      chk("t6.done_seen", 32'(done), 32'h1);
      chk("t6.beats", 32'(beats), 32'd16);
      start_s[1] = 1'b1;
      tick();
      start_s[1] = 1'b0;
      repeat (8) tick();
      #1;
      chk("t6.at_beat8", da_a[1], 32'd8);
      reset = 1'b0;
      #1;
      chk("t6.rst_valid", 32'(dv_a[1]), 32'h0);
      chk("t6.rst_busy",  32'(db_a[1]), 32'h0);
      chk("t6.rst_addr",  da_a[1], 32'h0);
      tick();
      #1;
      chk("t6.rst_no_done", 32'(dn_a[1]), 32'h0);
      reset = 1'b1;
      start_s[1] = 1'b1;
      tick();
      start_s[1] = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk($sformatf("t6.post_addr[%0d]", i), da_a[1], 32'(i));
         chk($sformatf("t6.post_data[%0d]", i), dd_a[1], 32'h0);
         tick();
      end

      // randomized traffic on all three configurations
      idle();
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 3; k++) begin
            we_s[k]    = 1'($urandom_range(0, 1));
            wa_s[k]    = $urandom & AM[k];
            wd_s[k]    = $urandom & MSK[k];
            ra1_s[k]   = ($urandom_range(0, 3) == 0) ? wa_s[k] : ($urandom & AM[k]);
            ra2_s[k]   = $urandom & AM[k];
            start_s[k] = ($urandom_range(0, 15) == 0);
            ready_s[k] = ($urandom_range(0, 3) != 0);
         end
         if ((c % 500) == 250) begin
            reset = 1'b0;
            #1;
            reset = 1'b1;
         end
         tick();
      end
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_scan.md
Name: regfile_scan

Overview:
- Parametrised general-purpose register file for the RISC-V core. It is the successor of the fixed 32x32 two-read-port file.
- Width, depth and the hard-wired zero register are configurable.
- Adds optional write-to-read bypass for pipelined datapaths.
- Replaces the 32 parallel debug buses with a sequential dump port: a ready/valid register scanner that streams every register to the debug/testbench side.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (2..32)
AW, 5, address width; must satisfy 2**AW >= NREGS
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
we  in  1  write enable
wa  in  AW  write address
wd  in  XLEN  write data
ra1  in  AW  read address, port 1
ra2  in  AW  read address, port 2
rd1  out  XLEN  read data, port 1 (combinational)
rd2  out  XLEN  read data, port 2 (combinational)
dump_start  in  1  one-cycle request to start a scan
dump_ready  in  1  consumer accepts the current dump beat
dump_valid  out  1  dump beat valid
dump_addr  out  AW  index of the register in the current beat
dump_data  out  XLEN  contents of the register in the current beat
dump_busy  out  1  scan in progress
dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- One clock, `clock`. Reset `reset` is asynchronous and active-low.
- While `reset` is 0:
  - all registers are 0;
  - FSM is in IDLE;
  - dump_valid, dump_busy and dump_done are 0;
  - dump_addr and dump_data are 0.
- Write:
  - At the rising edge, if we=1 then regs[wa] <= wd.
  - The write is ignored if wa >= NREGS.
  - The write is ignored if ZERO_REG=1 and wa=0.
- Read (rdN, combinational, zero latency; same rules for both ports):
  - raN >= NREGS -> 0.
  - ZERO_REG=1 and raN=0 -> 0.
  - BYPASS=1, we=1, wa=raN and the write is legal -> wd.
  - Otherwise -> regs[raN].
  - BYPASS=0: a read returns the pre-edge value; the new value is visible from the cycle after the write.
- Dump FSM, states IDLE and SCAN:
  - IDLE, dump_start=1 -> SCAN. At that edge: idx <= 0, dump_data <= regs[0], dump_valid <= 1.
  - dump_busy = (state == SCAN). dump_addr = idx.
  - SCAN, dump_valid=1 and dump_ready=1, idx < NREGS-1:
    - idx <= idx+1;
    - dump_data <= regs[idx+1];
    - dump_valid stays 1 (back-to-back beats allowed, 1 beat/cycle).
  - SCAN, dump_valid=1 and dump_ready=1, idx = NREGS-1:
    - next state IDLE;
    - dump_valid <= 0;
    - dump_done <= 1 for exactly one cycle;
    - dump_addr and dump_data hold their last values.
  - SCAN, dump_ready=0: dump_addr and dump_data are held stable (registered snapshot).
  - A write to the register currently presented does not alter dump_data. It is reflected only if that register is loaded again later.
  - Snapshot load uses pre-edge contents: a write at the same edge as the load is not included, regardless of BYPASS.
  - With ZERO_REG=1, the beat for register 0 carries 0.
  - dump_start while busy is ignored. dump_start in the same cycle as dump_done=1 starts a new scan; the FSM is already in IDLE.
  - dump_ready is don't-care while dump_valid=0.
- Reset mid-scan:
  - aborts immediately; outputs go to reset values;
  - no dump_done pulse;
  - register contents are lost (cleared).
- Scan and read/write ports operate fully concurrently; no stalls either way.
- Minimum scan length: NREGS cycles from the first dump_valid to dump_done.

Test Plan:
1. Reset, then write x5=0xDEADBEEF; next cycle ra1=5 -> rd1=0xDEADBEEF, rd2 (ra2=6) = 0. Assert reset mid-operation -> rd1=0.
2. we=1, wa=0, wd=0x1234 -> ra1=0 reads 0 (ZERO_REG=1). Rebuild with ZERO_REG=0 -> reads 0x1234 next cycle.
3. BYPASS=1: we=1, wa=7, wd=0xA5A5A5A5, ra1=7 in the same cycle -> rd1=0xA5A5A5A5 before the edge. With BYPASS=0 -> old value 0 until after the edge.
4. Load xi=i*0x11 for i=1..31; pulse dump_start with dump_ready held 1 -> 32 consecutive beats, dump_addr 0..31, dump_data 0,0x11,...,0x20F. dump_done is one cycle after beat 31; dump_busy is 0 after it.
5. Scan with dump_ready toggling 1,0,0,1; hold ready=0 on beat 3 while writing x3=0xFFFF_FFFF -> dump_data stays 0x33 during the stall. A second scan returns 0xFFFFFFFF at beat 3. dump_start pulsed mid-scan is ignored (exactly 32 beats).
6. Parameter sweep NREGS=16, XLEN=16, AW=4: full scan gives 16 beats. Write/read to the top index (15) works. Reset asserted at beat 8 -> dump_valid=0 immediately, no done pulse. A new start after reset gives beats from address 0 with all data 0.
